// File: rtl/perf_pkg.sv
// Shared types and constants for the performance-counter unit.
package perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_FROZEN = 2'd2
    } state_e;

    // Event channel assignments used by the core hookup.
    localparam int EV_INST  = 0;
    localparam int EV_ICREQ = 1;
    localparam int EV_ICHIT = 2;
    localparam int EV_DCREQ = 3;
    localparam int EV_DCHIT = 4;
    localparam int EV_STALL = 5;

endpackage

// File: rtl/perf_counter_cell.sv
// One event counter with a sticky overflow flag; wraps or saturates at all-ones.
module perf_counter_cell #(
    parameter int CNT_WIDTH = 32,
    parameter int SAT_MODE  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] cnt_d_o,
    output logic                 ovf_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i) begin
            if (&cnt_q) begin
                ovf_d = 1'b1;
                cnt_d = (SAT_MODE != 0) ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // The post-increment value is exported so shadows can capture this cycle's count.
    assign cnt_d_o = cnt_d;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/perf_event_counters.sv
// Performance-counter unit: event and cycle counters, halt freeze, shadow bank and
// a one-cycle-latency readout port.
module perf_event_counters
    import perf_pkg::*;
#(
    parameter int NUM_EVENTS = 8,
    parameter int CNT_WIDTH  = 32,
    parameter int SAT_MODE   = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              enable,
    input  logic                              clear,
    input  logic [NUM_EVENTS-1:0]             event_i,
    input  logic                              halt_i,
    input  logic                              snap_req,
    input  logic                              rd_req,
    input  logic [$clog2(NUM_EVENTS+1)-1:0]   rd_sel,
    output logic [CNT_WIDTH-1:0]              rd_data,
    output logic                              rd_valid,
    output logic [NUM_EVENTS:0]               ovf_flags,
    output logic                              frozen
);

    localparam int NUM_CNT = NUM_EVENTS + 1;
    localparam int SEL_W   = $clog2(NUM_EVENTS + 1);

    state_e               state_q, state_d;
    logic                 count_en;
    logic                 halt_edge;
    logic [NUM_CNT-1:0]   inc_vec;
    logic                 snap_load;
    logic [CNT_WIDTH-1:0] live_d   [NUM_CNT];
    logic [CNT_WIDTH-1:0] shadow_q [NUM_CNT];
    logic [CNT_WIDTH-1:0] shadow_d [NUM_CNT];
    logic [CNT_WIDTH-1:0] rd_mux;
    logic [CNT_WIDTH-1:0] rd_data_q;
    logic                 rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        count_en  = 1'b0;
        halt_edge = 1'b0;
        unique case (state_q)
            ST_IDLE:   if (enable) state_d = ST_COUNT;
            ST_COUNT: begin
                count_en = 1'b1;
                if (halt_i) begin
                    state_d   = ST_FROZEN;
                    halt_edge = 1'b1;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FROZEN: state_d = ST_FROZEN;
            default:   state_d = ST_IDLE;
        endcase
        // Clear overrides everything, including the halt freeze.
        if (clear) begin
            state_d   = ST_IDLE;
            count_en  = 1'b0;
            halt_edge = 1'b0;
        end
    end

    // Top slot is the cycle counter, which increments on every counting cycle.
    assign inc_vec = {count_en, event_i & {NUM_EVENTS{count_en}}};

    for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
        perf_counter_cell #(
            .CNT_WIDTH (CNT_WIDTH),
            .SAT_MODE  (SAT_MODE)
        ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc_i   (inc_vec[k]),
            .clr_i   (clear),
            .cnt_d_o (live_d[k]),
            .ovf_o   (ovf_flags[k])
        );
    end

    assign snap_load = !clear && (snap_req || halt_edge);

    always_comb begin
        for (int k = 0; k < NUM_CNT; k++) begin
            shadow_d[k] = shadow_q[k];
            if (clear)          shadow_d[k] = '0;
            else if (snap_load) shadow_d[k] = live_d[k];
        end
    end

    // NOTE: the shadow bank is reset because its contents are architecturally visible on rd_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CNT; k++) shadow_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CNT; k++) shadow_q[k] <= shadow_d[k];
        end
    end

    // Reading from shadow_d lets a same-cycle snapshot be returned by the read.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_CNT; k++) begin
            if (rd_sel == SEL_W'(k)) rd_mux = shadow_d[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_req;
            if (rd_req) rd_data_q <= rd_mux;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign frozen   = (state_q == ST_FROZEN);

endmodule

// File: tb/tb_perf_event_counters.sv
// Bench for perf_event_counters: wrapping and saturating 8-bit instances driven in
// lockstep and compared against an unbounded-count reference model.
module tb_perf_event_counters;
    import perf_pkg::*;

    localparam int NE = 8;
    localparam int CW = 8;
    localparam int NC = NE + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable, clear, halt, snap, rd_req;
    logic [NE-1:0] ev;
    logic [3:0]    rd_sel;

    logic [CW-1:0] rd_data_w, rd_data_s;
    logic          rd_valid_w, rd_valid_s;
    logic [NE:0]   ovf_w, ovf_s;
    logic          frozen_w, frozen_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    perf_event_counters #(.NUM_EVENTS(NE), .CNT_WIDTH(CW), .SAT_MODE(0)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .event_i(ev),
        .halt_i(halt), .snap_req(snap), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_data(rd_data_w), .rd_valid(rd_valid_w), .ovf_flags(ovf_w), .frozen(frozen_w)
    );

    perf_event_counters #(.NUM_EVENTS(NE), .CNT_WIDTH(CW), .SAT_MODE(1)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .event_i(ev),
        .halt_i(halt), .snap_req(snap), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_data(rd_data_s), .rd_valid(rd_valid_s), .ovf_flags(ovf_s), .frozen(frozen_s)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: true (unbounded) event counts; each DUT view is derived from them.
    typedef enum {M_IDLE, M_RUN, M_HALTED} mmode_e;
    mmode_e m_mode;
    longint m_cnt [NC];
    longint m_shd [NC];
    bit     m_valid;
    longint m_rd;

    function automatic logic [63:0] wrap_view(input longint t);
        return 64'(t % 256);
    endfunction

    function automatic logic [63:0] sat_view(input longint t);
        return (t > 255) ? 64'd255 : 64'(t);
    endfunction

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_valid = 1'b0;
        m_rd    = 0;
        for (int k = 0; k < NC; k++) begin
            m_cnt[k] = 0;
            m_shd[k] = 0;
        end
    endtask

    task automatic model_edge();
        bit run;
        if (clear) begin
            for (int k = 0; k < NC; k++) begin
                m_cnt[k] = 0;
                m_shd[k] = 0;
            end
            m_mode = M_IDLE;
        end else begin
            run = (m_mode == M_RUN);
            if (run) begin
                m_cnt[NE]++;
                for (int k = 0; k < NE; k++) if (ev[k]) m_cnt[k]++;
            end
            if (snap || (run && halt)) for (int k = 0; k < NC; k++) m_shd[k] = m_cnt[k];
            case (m_mode)
                M_IDLE:  if (enable) m_mode = M_RUN;
                M_RUN:   if (halt) m_mode = M_HALTED; else if (!enable) m_mode = M_IDLE;
                default: m_mode = m_mode;
            endcase
        end
        m_valid = rd_req;
        if (rd_req) m_rd = (rd_sel < NC) ? m_shd[rd_sel] : 0;
    endtask

    task automatic compare_all();
        logic [NE:0] exp_ovf;
        for (int k = 0; k < NC; k++) exp_ovf[k] = (m_cnt[k] > 255);
        check("valid_wrap", rd_valid_w, m_valid);
        check("valid_sat", rd_valid_s, m_valid);
        check("data_wrap", rd_data_w, wrap_view(m_rd));
        check("data_sat", rd_data_s, sat_view(m_rd));
        check("ovf_wrap", ovf_w, exp_ovf);
        check("ovf_sat", ovf_s, exp_ovf);
        check("frozen_wrap", frozen_w, m_mode == M_HALTED);
        check("frozen_sat", frozen_s, m_mode == M_HALTED);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic quiet_inputs();
        clear  = 1'b0;
        halt   = 1'b0;
        snap   = 1'b0;
        rd_req = 1'b0;
        rd_sel = '0;
        ev     = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        enable = 1'b0;
        quiet_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        #2 rst_n = 1'b1;

        // Basic counting, snapshot and read of an event and the cycle counter.
        enable = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            ev = '0;
            ev[EV_INST] = (i % 2 == 0);
            step();
        end
        ev = '0;
        snap = 1'b1; rd_req = 1'b1; rd_sel = 4'(EV_INST);
        step();
        check("t1_ev0_wrap", rd_data_w, 5);
        check("t1_ev0_sat", rd_data_s, 5);
        snap = 1'b0; rd_sel = 4'(NE);
        step();
        check("t1_cyc_wrap", rd_data_w, 11);
        rd_req = 1'b0;

        // 257 pulses on an 8-bit counter: wrap to 1 or saturate at 255, flag set.
        clear = 1'b1; enable = 1'b0;
        step();
        clear = 1'b0; enable = 1'b1;
        step();
        for (int i = 0; i < 257; i++) begin
            ev = '0;
            ev[EV_ICREQ] = 1'b1;
            step();
        end
        ev = '0;
        snap = 1'b1; rd_req = 1'b1; rd_sel = 4'(EV_ICREQ);
        step();
        check("t2_cnt_wrap", rd_data_w, 1);
        check("t2_cnt_sat", rd_data_s, 255);
        check("t2_ovf_wrap", ovf_w[EV_ICREQ], 1);
        check("t2_ovf_sat", ovf_s[EV_ICREQ], 1);
        quiet_inputs();

        // Clear coinciding with an event wins; unit returns to idle with flags cleared.
        for (int i = 0; i < 7; i++) begin
            ev = '0;
            ev[EV_DCREQ] = 1'b1;
            step();
        end
        ev = '0;
        snap = 1'b1; rd_req = 1'b1; rd_sel = 4'(EV_DCREQ);
        step();
        check("t4_pre_clear", rd_data_w, 7);
        quiet_inputs();
        clear = 1'b1; ev[EV_DCREQ] = 1'b1;
        step();
        check("t4_ovf_wrap", ovf_w, 0);
        check("t4_ovf_sat", ovf_s, 0);
        quiet_inputs();
        snap = 1'b1; rd_req = 1'b1; rd_sel = 4'(EV_DCREQ);
        step();
        check("t4_cnt_cleared", rd_data_w, 0);
        snap = 1'b0; rd_sel = 4'(NE);
        step();
        check("t4_idle_cyc", rd_data_w, 0);
        quiet_inputs();

        // Halt together with an event: the halt cycle counts, then everything freezes.
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            ev = '0;
            ev[EV_ICHIT] = 1'b1;
            step();
        end
        halt = 1'b1;
        step();
        check("t3_frozen_wrap", frozen_w, 1);
        check("t3_frozen_sat", frozen_s, 1);
        quiet_inputs();
        rd_req = 1'b1; rd_sel = 4'(EV_ICHIT);
        step();
        check("t3_halt_snap", rd_data_w, 4);
        rd_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ev = NE'($urandom);
            step();
        end
        ev = '0;
        snap = 1'b1; rd_req = 1'b1; rd_sel = 4'(EV_ICHIT);
        step();
        check("t3_still_frozen", rd_data_w, 4);
        quiet_inputs();

        // Back-to-back reads and an out-of-range select.
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 13; i++) begin
            ev = NE'($urandom);
            step();
        end
        ev = '0; snap = 1'b1;
        step();
        snap = 1'b0; rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_sel = 4'(i);
            step();
            check("t5_b2b_valid", rd_valid_w, 1);
        end
        rd_sel = 4'(NE + 3);
        step();
        check("t5_oob_valid", rd_valid_w, 1);
        check("t5_oob_data", rd_data_w, 0);
        quiet_inputs();
        step();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            clear  = ($urandom_range(0, 79) == 0);
            halt   = ($urandom_range(0, 49) == 0);
            snap   = ($urandom_range(0, 5) == 0);
            rd_req = 1'($urandom_range(0, 1));
            rd_sel = 4'($urandom_range(0, 15));
            ev     = NE'($urandom);
            step();
        end
        quiet_inputs();

        // Asynchronous reset mid-count with a read pending.
        clear = 1'b1; enable = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ev = NE'($urandom);
            step();
        end
        snap = 1'b1;
        step();
        quiet_inputs();
        #2;
        rd_req = 1'b1; rd_sel = 4'(NE);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_data_wrap", rd_data_w, 0);
        check("t6_data_sat", rd_data_s, 0);
        check("t6_valid", rd_valid_w, 0);
        check("t6_ovf", ovf_w, 0);
        check("t6_frozen", frozen_w, 0);
        @(posedge clk);
        #1;
        check("t6_no_valid_wrap", rd_valid_w, 0);
        check("t6_no_valid_sat", rd_valid_s, 0);
        #2;
        rst_n = 1'b1;
        enable = 1'b0;
        quiet_inputs();
        repeat (3) step();
        snap = 1'b1; rd_req = 1'b1; rd_sel = 4'(NE);
        step();
        check("t6_idle_cyc", rd_data_w, 0);
        quiet_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
